// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// oversampling constants and the baud tick divisor calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

  // Floored clocks-per-tick; clamped to 1 so a too-fast baud still ticks every clock.
  function automatic int uart_divisor(input int clk_freq, input int baud);
    int d;
    d = clk_freq / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO: head is the registered entry at the read pointer,
// so data is visible as soon as the FIFO is non-empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int p_DEPTH = 4,
  parameter int p_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [p_WIDTH-1:0] din,
  output logic [p_WIDTH-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(p_DEPTH);

  logic [p_WIDTH-1:0] mem [p_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               do_pop;
  logic               do_push;

  assign full    = (count == (AW+1)'(p_DEPTH));
  assign empty   = (count == {(AW+1){1'b0}});
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_push = push & (~full | do_pop);

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < p_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver with 16x oversampling, feeding a show-ahead byte FIFO
// drained by a valid/ready handshake; framing and overrun errors pulse for one clock.
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 115200,
  parameter int p_DEPTH        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = uart_divisor(clk_freq, uart_baud_rate);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  rx_state_t state;
  logic          rxd_meta;
  logic          rxd_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    samp_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          byte_done;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;

  assign tick     = (state != IDLE) && (div_cnt == DW'(DIV - 1));
  assign busy     = (state != IDLE);
  assign rx_valid = ~fifo_empty;
  assign fifo_pop = rx_valid & rx_ready;

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // Baud tick divider; held at zero in IDLE so every frame starts phase-aligned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if ((state == IDLE) || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Receive FSM; returns to IDLE at mid stop bit so back-to-back start edges are caught.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      samp_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shift     <= 8'hFF;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state    <= START;
            samp_cnt <= 4'd0;
          end
        end
        START: begin
          if (tick) begin
            if (samp_cnt == 4'(MID_SAMPLE - 1)) begin
              samp_cnt <= 4'd0;
              bit_cnt  <= 3'd0;
              state    <= rxd_s ? IDLE : DATA;
            end else begin
              samp_cnt <= samp_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (samp_cnt == 4'(OVERSAMPLE - 1)) begin
              samp_cnt <= 4'd0;
              shift    <= {rxd_s, shift[7:1]};
              if (bit_cnt == 3'(DATA_BITS - 1)) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              samp_cnt <= samp_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (samp_cnt == 4'(OVERSAMPLE - 1)) begin
              samp_cnt <= 4'd0;
              if (rxd_s) begin
                byte_done <= 1'b1;
                state     <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_HI;
              end
            end else begin
              samp_cnt <= samp_cnt + 4'd1;
            end
          end
        end
        WAIT_HI: begin
          if (rxd_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Overrun pulse: a completed byte found the FIFO full with no pop to make room.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else begin
      overrun <= byte_done & fifo_full & ~fifo_pop;
    end
  end

  uart_rx_fifo #(
    .p_DEPTH (p_DEPTH),
    .p_WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (byte_done),
    .pop   (fifo_pop),
    .din   (shift),
    .head  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit at 16 clocks per bit; expected bytes are
// queued as frames are sent and compared as the FIFO is drained.
module tb_uart_rx_unit;

  localparam int BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_unit #(
    .clk_freq       (16000000),
    .uart_baud_rate (1000000),
    .p_DEPTH        (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rxd  (uart_rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (frame_err && overrun) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] next_exp();
    if (exp_q.size() > 0) return {24'h0, exp_q.pop_front()};
    else return 32'hFFFF_FFFF;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    int n = 0;
    while (!rx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'h0, rx_valid}, 32'h1);
    if (rx_valid) begin
      check(tag, {24'h0, rx_data}, next_exp());
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic drain_live(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (rx_valid && rx_ready) check("t6_live_data", {24'h0, rx_data}, next_exp());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0, t0, lat, n;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    check("rst_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_data", {24'h0, rx_data}, 32'h0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // 1: single byte, latency from falling start edge to rx_valid
    fe0 = fe_cnt; ov0 = ov_cnt; t0 = cyc; lat = -1;
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1);
      begin
        n = 0;
        while (lat < 0 && n < 300) begin
          @(negedge clk);
          n++;
          if (rx_valid) lat = cyc - t0;
        end
      end
    join
    check("t1_latency_window", {31'h0, (lat >= 154 && lat <= 156)}, 32'h1);
    repeat (16) @(negedge clk);
    pop_check("t1_data");
    check("t1_empty_after", {31'h0, rx_valid}, 32'h0);
    check("t1_no_fe", fe_cnt - fe0, 0);
    check("t1_no_ov", ov_cnt - ov0, 0);

    // 2: short low glitch rejected
    fe0 = fe_cnt;
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    check("t2_busy_in_glitch", {31'h0, busy}, 32'h1);
    uart_rxd = 1'b1;
    n = 0;
    while (busy && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("t2_busy_drop", {31'h0, busy}, 32'h0);
    repeat (40) @(negedge clk);
    check("t2_no_push", {31'h0, rx_valid}, 32'h0);
    check("t2_no_fe", fe_cnt - fe0, 0);

    // 3: overrun on fifth byte into a depth-4 FIFO
    ov0 = ov_cnt; fe0 = fe_cnt;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      if (i <= 4) exp_q.push_back(b);
      send_frame(b, 1'b1);
      if (i == 4) check("t3_no_ov_before5", ov_cnt - ov0, 0);
    end
    repeat (4) @(negedge clk);
    check("t3_one_overrun", ov_cnt - ov0, 1);
    check("t3_no_fe", fe_cnt - fe0, 0);
    for (int i = 0; i < 4; i++) pop_check("t3_pop");
    check("t3_empty_after", {31'h0, rx_valid}, 32'h0);

    // 4: framing error, line held low, busy until high
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'hA3, 1'b0);
    repeat (32) @(negedge clk);
    check("t4_one_fe", fe_cnt - fe0, 1);
    check("t4_busy_low", {31'h0, busy}, 32'h1);
    check("t4_no_push", {31'h0, rx_valid}, 32'h0);
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_busy_released", {31'h0, busy}, 32'h0);
    check("t4_no_ov", ov_cnt - ov0, 0);
    repeat (16) @(negedge clk);

    // 5: reset mid-frame empties FIFO and abandons frame
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (8) @(negedge clk);
    check("t5_pre_valid", {31'h0, rx_valid}, 32'h1);
    b = 8'h3C;
    uart_rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    uart_rxd = b[4];
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    uart_rxd = 1'b1;
    exp_q.delete();
    check("t5_rst_valid", {31'h0, rx_valid}, 32'h0);
    check("t5_rst_busy", {31'h0, busy}, 32'h0);
    check("t5_rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("t5_rst_overrun", {31'h0, overrun}, 32'h0);
    check("t5_rst_data", {24'h0, rx_data}, 32'h0);
    repeat (48) @(negedge clk);
    check("t5_idle_after", {31'h0, busy | rx_valid}, 32'h0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    repeat (16) @(negedge clk);
    pop_check("t5_c3");
    check("t5_alone", {31'h0, rx_valid}, 32'h0);

    // 6a: back-to-back 00/FF drained live
    ov0 = ov_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (16) @(negedge clk);
      end
      drain_live(2 * 10 * BIT_CLKS + 16);
    join
    rx_ready = 1'b0;
    check("t6_all_delivered", exp_q.size(), 0);
    check("t6_empty", {31'h0, rx_valid}, 32'h0);

    // 6b: pop coincides with a push into a full FIFO
    for (int i = 0; i < 4; i++) begin
      b = 8'h11 * 8'(i + 1);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    exp_q.push_back(8'h99);
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (155) @(negedge clk);
        check("t6_corner_head", {24'h0, rx_data}, next_exp());
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("t6_no_overrun", ov_cnt - ov0, 0);
    for (int i = 0; i < 4; i++) pop_check("t6_corner_pop");
    check("t6_corner_empty", {31'h0, rx_valid}, 32'h0);
    check("never_both_flags", both_cnt, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
